// File: rtl/regfile_write_arbiter.sv
// Purpose : shares the regfile write port between writeback (fixed priority) and NREQ-1
//           auxiliary writers, each behind a 1-entry holding buffer drained round-robin.
// Latency : 1 edge from sample to registered rf_* write; regfile captures on the following negedge.
// Backpr. : req_ready = buffer empty; wb_stall raised after STARVE_LIMIT cycles of aux starvation.
// Ports   : clk/clr (async, active-high); wb_* writeback request; req_valid/addr/data/ready aux
//           handshakes (packed, requester i at slice i-1); rf_we/addr/data + grant_id registered
//           write; wb_stall registered stall; pending_mask combinational per-register buffer hits.
module regfile_write_arbiter #(
   parameter int NREQ         = 3,
   parameter int AW           = 5,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                        clk,
   input  logic                        clr,
   input  logic                        wb_en,
   input  logic [AW-1:0]               wb_addr,
   input  logic [DW-1:0]               wb_data,
   output logic                        wb_stall,
   input  logic [NREQ-2:0]             req_valid,
   input  logic [(NREQ-1)*AW-1:0]      req_addr,
   input  logic [(NREQ-1)*DW-1:0]      req_data,
   output logic [NREQ-2:0]             req_ready,
   output logic                        rf_we,
   output logic [AW-1:0]               rf_addr,
   output logic [DW-1:0]               rf_data,
   output logic [$clog2(NREQ)-1:0]     grant_id,
   output logic [(2**AW)-1:0]          pending_mask
);

   localparam int NA = NREQ - 1;
   localparam int GW = $clog2(NREQ);
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic [NA-1:0]    full_q, full_d;
   logic [NA*AW-1:0] buf_addr_q, buf_addr_d;
   logic [NA*DW-1:0] buf_data_q, buf_data_d;
   logic [GW-1:0]    rr_q, rr_d;
   logic [CW-1:0]    starve_q, starve_d;
   logic             wb_stall_q, wb_stall_d;
   logic             rf_we_q, rf_we_d;
   logic [AW-1:0]    rf_addr_q, rf_addr_d;
   logic [DW-1:0]    rf_data_q, rf_data_d;
   logic [GW-1:0]    grant_id_q, grant_id_d;

   logic             rr_found;
   logic [GW-1:0]    rr_win;
   logic             aux_issue;

   // Round-robin winner: first full buffer at or above the pointer, else the first full one
   // below it (the wrap from NREQ-1 back to 1).
   always_comb begin
      rr_found = 1'b0;
      rr_win   = '0;
      for (int i = 0; i < NA; i++) begin
         if (!rr_found && full_q[i] && ((i + 1) >= int'(rr_q))) begin
            rr_found = 1'b1;
            rr_win   = GW'(i + 1);
         end
      end
      for (int i = 0; i < NA; i++) begin
         if (!rr_found && full_q[i]) begin
            rr_found = 1'b1;
            rr_win   = GW'(i + 1);
         end
      end
   end

   always_comb begin
      full_d     = full_q;
      buf_addr_d = buf_addr_q;
      buf_data_d = buf_data_q;
      rr_d       = rr_q;
      starve_d   = starve_q;
      wb_stall_d = wb_stall_q;
      rf_we_d    = 1'b0;
      rf_addr_d  = rf_addr_q;
      rf_data_d  = rf_data_q;
      grant_id_d = grant_id_q;
      aux_issue  = 1'b0;

      // Stall forces a buffer drain; otherwise writeback to r0 counts as idle.
      if (wb_stall_q && rr_found) begin
         aux_issue = 1'b1;
      end else if (wb_en && (wb_addr != '0)) begin
         rf_we_d    = 1'b1;
         rf_addr_d  = wb_addr;
         rf_data_d  = wb_data;
         grant_id_d = '0;
      end else if (rr_found) begin
         aux_issue = 1'b1;
      end

      if (aux_issue) begin
         rf_we_d    = 1'b1;
         grant_id_d = rr_win;
         rr_d       = (rr_win == GW'(NA)) ? GW'(1) : rr_win + GW'(1);
         for (int i = 0; i < NA; i++) begin
            if (rr_win == GW'(i + 1)) begin
               rf_addr_d = buf_addr_q[i*AW +: AW];
               rf_data_d = buf_data_q[i*DW +: DW];
               full_d[i] = 1'b0;
            end
         end
      end

      // Only empty buffers accept, so an accept never collides with the issue above.
      // Writes to r0 are swallowed without occupying the buffer.
      for (int i = 0; i < NA; i++) begin
         if (req_valid[i] && !full_q[i] && (req_addr[i*AW +: AW] != '0)) begin
            full_d[i]              = 1'b1;
            buf_addr_d[i*AW +: AW] = req_addr[i*AW +: AW];
            buf_data_d[i*DW +: DW] = req_data[i*DW +: DW];
         end
      end

      if (aux_issue) begin
         starve_d   = '0;
         wb_stall_d = 1'b0;
      end else if (|full_q) begin
         if (starve_q != CW'(STARVE_LIMIT)) begin
            starve_d = starve_q + CW'(1);
         end
         if (starve_d == CW'(STARVE_LIMIT)) begin
            wb_stall_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         full_q     <= '0;
         buf_addr_q <= '0;
         buf_data_q <= '0;
         rr_q       <= GW'(1);
         starve_q   <= '0;
         wb_stall_q <= 1'b0;
         rf_we_q    <= 1'b0;
         rf_addr_q  <= '0;
         rf_data_q  <= '0;
         grant_id_q <= '0;
      end else begin
         full_q     <= full_d;
         buf_addr_q <= buf_addr_d;
         buf_data_q <= buf_data_d;
         rr_q       <= rr_d;
         starve_q   <= starve_d;
         wb_stall_q <= wb_stall_d;
         rf_we_q    <= rf_we_d;
         rf_addr_q  <= rf_addr_d;
         rf_data_q  <= rf_data_d;
         grant_id_q <= grant_id_d;
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < NA; i++) begin
         if (full_q[i]) begin
            pending_mask[buf_addr_q[i*AW +: AW]] = 1'b1;
         end
      end
   end

   assign req_ready = ~full_q;
   assign wb_stall  = wb_stall_q;
   assign rf_we     = rf_we_q;
   assign rf_addr   = rf_addr_q;
   assign rf_data   = rf_data_q;
   assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Purpose : directed bench for regfile_write_arbiter with hand-computed expectations.
// Latency : inputs driven 1 time unit after posedge, outputs checked at the same point.
// Backpr. : exercises req_ready, wb_stall starvation release and async clr.
module tb_regfile_write_arbiter;

   logic          clk;
   logic          clr;
   logic          wb_en;
   logic [4:0]    wb_addr;
   logic [31:0]   wb_data;
   logic          wb_stall;
   logic [1:0]    req_valid;
   logic [9:0]    req_addr;
   logic [63:0]   req_data;
   logic [1:0]    req_ready;
   logic          rf_we;
   logic [4:0]    rf_addr;
   logic [31:0]   rf_data;
   logic [1:0]    grant_id;
   logic [31:0]   pending_mask;

   int checks   = 0;
   int failures = 0;

   regfile_write_arbiter #(
      .NREQ(3), .AW(5), .DW(32), .STARVE_LIMIT(8)
   ) dut (
      .clk          (clk),
      .clr          (clr),
      .wb_en        (wb_en),
      .wb_addr      (wb_addr),
      .wb_data      (wb_data),
      .wb_stall     (wb_stall),
      .req_valid    (req_valid),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .rf_we        (rf_we),
      .rf_addr      (rf_addr),
      .rf_data      (rf_data),
      .grant_id     (grant_id),
      .pending_mask (pending_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h @%0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_aux(input logic [1:0] v, input logic [4:0] a1, input logic [31:0] d1,
                          input logic [4:0] a2, input logic [31:0] d2);
      req_valid = v;
      req_addr  = {a2, a1};
      req_data  = {d2, d1};
   endtask

   task automatic chk_wr(input string tag, input logic [1:0] gid, input logic [4:0] a,
                         input logic [31:0] d);
      chk({tag, "_we"},   64'(rf_we),    64'(1));
      chk({tag, "_gid"},  64'(grant_id), 64'(gid));
      chk({tag, "_addr"}, 64'(rf_addr),  64'(a));
      chk({tag, "_data"}, 64'(rf_data),  64'(d));
   endtask

   initial begin
      clr     = 1'b1;
      wb_en   = 1'b0;
      wb_addr = '0;
      wb_data = '0;
      set_aux(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

      // Reset state
      tick();
      tick();
      chk("rst_we",    64'(rf_we),        64'(0));
      chk("rst_addr",  64'(rf_addr),      64'(0));
      chk("rst_data",  64'(rf_data),      64'(0));
      chk("rst_gid",   64'(grant_id),     64'(0));
      chk("rst_stall", 64'(wb_stall),     64'(0));
      clr = 1'b0;

      // Idle after reset release
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("idle_we",    64'(rf_we),        64'(0));
         chk("idle_rdy",   64'(req_ready),    64'(3));
         chk("idle_pend",  64'(pending_mask), 64'(0));
         chk("idle_stall", 64'(wb_stall),     64'(0));
      end

      // Single writeback
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
      tick();
      chk_wr("wb", 2'd0, 5'd5, 32'hDEADBEEF);
      wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
      tick();
      chk("wb_done_we",   64'(rf_we),   64'(0));
      chk("wb_hold_addr", 64'(rf_addr), 64'(5));
      chk("wb_hold_data", 64'(rf_data), 64'(32'hDEADBEEF));

      // Two aux requesters at once, pointer at 1
      set_aux(2'b11, 5'd3, 32'h111, 5'd7, 32'h222);
      tick();
      chk("rr1_acc_we",   64'(rf_we),        64'(0));
      chk("rr1_acc_pend", 64'(pending_mask), 64'(32'h88));
      chk("rr1_acc_rdy",  64'(req_ready),    64'(0));
      set_aux(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      tick();
      chk_wr("rr1_g1", 2'd1, 5'd3, 32'h111);
      chk("rr1_g1_pend", 64'(pending_mask), 64'(32'h80));
      chk("rr1_g1_rdy",  64'(req_ready),    64'(1));
      tick();
      chk_wr("rr1_g2", 2'd2, 5'd7, 32'h222);
      chk("rr1_g2_pend", 64'(pending_mask), 64'(0));
      tick();
      chk("rr1_idle_we", 64'(rf_we), 64'(0));

      // Repeat: order stays 1 then 2 after the wrap
      set_aux(2'b11, 5'd10, 32'h333, 5'd12, 32'h444);
      tick();
      chk("rr2_acc_pend", 64'(pending_mask), 64'(32'h1400));
      set_aux(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      tick();
      chk_wr("rr2_g1", 2'd1, 5'd10, 32'h333);
      tick();
      chk_wr("rr2_g2", 2'd2, 5'd12, 32'h444);

      // Requester 1 alone moves pointer to 2, so the next pair grants 2 first
      set_aux(2'b01, 5'd8, 32'h555, 5'd0, 32'h0);
      tick();
      set_aux(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      tick();
      chk_wr("rr3_g1", 2'd1, 5'd8, 32'h555);
      tick();
      set_aux(2'b11, 5'd11, 32'h666, 5'd13, 32'h777);
      tick();
      set_aux(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      tick();
      chk_wr("rr3_g2first", 2'd2, 5'd13, 32'h777);
      tick();
      chk_wr("rr3_g1second", 2'd1, 5'd11, 32'h666);
      tick();

      // Starvation under continuous writeback
      wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
      set_aux(2'b01, 5'd9, 32'h99, 5'd0, 32'h0);
      tick();
      set_aux(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      chk_wr("stv_acc", 2'd0, 5'd4, 32'h44);
      chk("stv_acc_pend", 64'(pending_mask), 64'(32'h200));
      for (int c = 1; c <= 7; c++) begin
         tick();
         chk("stv_wait_stall", 64'(wb_stall), 64'(0));
         chk("stv_wait_gid",   64'(grant_id), 64'(0));
      end
      tick();
      chk("stv_stall_up", 64'(wb_stall), 64'(1));
      chk("stv_last_wb",  64'(grant_id), 64'(0));
      tick();
      chk_wr("stv_aux", 2'd1, 5'd9, 32'h99);
      chk("stv_stall_dn", 64'(wb_stall),     64'(0));
      chk("stv_pend_dn",  64'(pending_mask), 64'(0));
      tick();
      chk_wr("stv_wb_again", 2'd0, 5'd4, 32'h44);
      wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
      tick();

      // Register 0 writes are dropped
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hAAAA;
      set_aux(2'b10, 5'd0, 32'h0, 5'd0, 32'hBBBB);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("r0_we",   64'(rf_we),        64'(0));
         chk("r0_rdy",  64'(req_ready),    64'(3));
         chk("r0_pend", 64'(pending_mask), 64'(0));
      end
      wb_en = 1'b0; wb_data = 32'h0;
      set_aux(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      tick();

      // Async clear mid-cycle with a write in flight and both buffers full (pointer is 2)
      wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'hC0FFEE;
      set_aux(2'b11, 5'd14, 32'hE1, 5'd15, 32'hE2);
      tick();
      wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
      set_aux(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      chk_wr("clr_pre", 2'd0, 5'd2, 32'hC0FFEE);
      chk("clr_pre_pend", 64'(pending_mask), 64'(32'hC000));
      #2;
      clr = 1'b1;
      #1;
      chk("clr_we",    64'(rf_we),        64'(0));
      chk("clr_rdy",   64'(req_ready),    64'(3));
      chk("clr_pend",  64'(pending_mask), 64'(0));
      chk("clr_addr",  64'(rf_addr),      64'(0));
      chk("clr_stall", 64'(wb_stall),     64'(0));
      tick();
      clr = 1'b0;
      set_aux(2'b11, 5'd20, 32'hF1, 5'd21, 32'hF2);
      tick();
      set_aux(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      tick();
      chk_wr("post_clr_g1", 2'd1, 5'd20, 32'hF1);
      tick();
      chk_wr("post_clr_g2", 2'd2, 5'd21, 32'hF2);
      tick();
      chk("post_clr_idle", 64'(rf_we), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between the pipeline writeback stage and NREQ-1 auxiliary writers (multdiv result, board/IO loader).
- Writeback has fixed priority. Each auxiliary writer has a valid/ready handshake into a 1-entry holding buffer. Buffers drain round-robin when writeback is idle.
- Starvation is bounded by a stall request to the pipeline.
- The arbiter sequences on posedge clk. Its registered outputs are stable across the following negedge, where the regfile flops capture.

Parameters:
- NREQ, 3, total requesters: index 0 is writeback, indices 1..NREQ-1 are auxiliary.
- AW, 5, register address width.
- DW, 32, data width.
- STARVE_LIMIT, 8, cycles an auxiliary entry may wait before wb_stall is raised.

Ports:
- clk  in  1  system clock; arbiter state updates on posedge.
- clr  in  1  reset, asynchronous, active-high.
- wb_en  in  1  writeback write request, fire-and-forget, never back-pressured except via wb_stall.
- wb_addr  in  AW  writeback destination register.
- wb_data  in  DW  writeback data.
- wb_stall  out  1  registered; pipeline must hold writeback while high.
- req_valid  in  NREQ-1  auxiliary request valid; bit i-1 is requester i.
- req_addr  in  (NREQ-1)*AW  packed auxiliary addresses.
- req_data  in  (NREQ-1)*DW  packed auxiliary data.
- req_ready  out  NREQ-1  buffer i empty; equals !full[i], driven from state only.
- rf_we  out  1  registered regfile write enable.
- rf_addr  out  AW  registered regfile write address.
- rf_data  out  DW  registered regfile write data.
- grant_id  out  clog2(NREQ)  registered source of the current rf_* write.
- pending_mask  out  2**AW  bit k set when any full buffer targets register k; used for hazard detection.

Behaviour:
- Reset (clr high, asynchronous):
  - All buffers empty.
  - rf_we=0, rf_addr=0, rf_data=0, grant_id=0, wb_stall=0.
  - Round-robin pointer set to requester 1; starvation counter 0.
  - Outputs change immediately on clr, not on the next edge.
  - clr mid-operation discards pending entries and kills an in-flight write before its negedge capture.
- Accept: on posedge, if req_valid[i] and req_ready[i], buffer i stores addr/data and becomes full.
  - Address 0 is accepted but discarded; the buffer stays empty.
  - req_ready is low while full, so per-requester throughput is 1 write per 2 cycles at best.
- Issue decision at each posedge, with priority in this order:
  - (a) wb_stall=1 and some buffer is full: issue the round-robin winner; ignore wb_en.
  - (b) wb_en=1 and wb_addr!=0: issue writeback, grant_id=0.
  - (c) otherwise issue the round-robin winner among full buffers.
  - (d) nothing to issue: rf_we=0, and rf_addr/rf_data hold their previous values.
- wb_en=1 with wb_addr=0 issues nothing, so buffers may drain that cycle.
- Round-robin:
  - Search starts at the pointer and wraps from NREQ-1 to 1.
  - After a grant to i, the pointer moves to i+1, wrapping to 1.
  - An issued buffer becomes empty at the same edge. It may accept a new request at the next edge, not the same one.
- Latency:
  - A request sampled at posedge N drives rf_* during cycle N+1 and is captured by the regfile at the negedge inside cycle N+1.
  - An auxiliary write's minimum latency from the accept edge is one further edge.
- Starvation:
  - The counter increments each cycle in which some buffer is full but no auxiliary write is issued. It resets to 0 on any auxiliary issue.
  - When the counter reaches STARVE_LIMIT, wb_stall is set at that edge.
  - wb_stall clears on the edge that issues the auxiliary write.
- Ordering:
  - No address-based reordering or killing: a buffered entry is written when granted, even if writeback wrote the same register meanwhile.
  - Consumers use pending_mask to avoid the hazard.
- pending_mask is combinational from buffer state. Duplicate addresses across buffers set one bit.

Test Plan:
- Reset release, no activity: rf_we=0, req_ready=all 1s, pending_mask=0, wb_stall=0 for 10 cycles.
- wb_en=1, addr=5, data=0xDEADBEEF at posedge N -> rf_we=1, rf_addr=5, rf_data=0xDEADBEEF, grant_id=0 during cycle N+1; rf_we=0 in cycle N+2.
- Requesters 1 and 2 both valid at the same edge (addrs 3, 7) with wb idle -> grants 1 then 2 on consecutive cycles; pending_mask=0x88 then 0x80 then 0. Repeat the stimulus -> order continues fairly (1, 2), pointer wraps correctly.
- wb_en held high (addr 4) with requester 1 full (addr 9) -> after STARVE_LIMIT=8 waiting cycles wb_stall=1; next issue grant_id=1, rf_addr=9; wb_stall falls the same edge.
- Writes to register 0 from wb and requester 2 -> rf_we never asserts; requester 2 sees req_ready stay 1 and pending_mask bit 0 stays 0.
- clr pulsed asynchronously mid-cycle while rf_we=1 and both buffers full -> rf_we drops immediately, req_ready=all 1s, pending_mask=0; first post-reset grant goes to requester 1.
